// File: rtl/shift_counter_pkg.sv
// Shared constants and seed helper for the shift-register counter family.
package shift_counter_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Widest counter the seed helper can describe; callers cast down to N.
   localparam int unsigned SEED_W = 64;

   // Ring seed is a single 1 in bit 0; Johnson seed is all zeros.
   function automatic logic [SEED_W-1:0] seed_of(input int unsigned n, input logic mode);
      logic [SEED_W-1:0] s;
      s = '0;
      if ((mode == MODE_RING) && (n >= 2)) begin
         s[0] = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/shift_counter_code_check.sv
// Combinational legality check of a ring or Johnson code word.
module shift_code_check
   import shift_counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] state,
   input  logic         mode,
   output logic         legal
);

   logic [N-2:0] edges;

   // Ring words are one-hot; Johnson words have at most one 0/1 boundary.
   always_comb begin
      edges = state[N-2:0] ^ state[N-1:1];
      legal = 1'b0;
      if (mode == MODE_RING) begin
         legal = ($countones(state) == 1);
      end else begin
         legal = ($countones(edges) <= 1);
      end
   end

endmodule

// File: rtl/shift_counter.sv
// Parametrised ring / Johnson shift counter with load and self-correction.
module shift_counter
   import shift_counter_pkg::*;
#(
   parameter int N        = 4,
   parameter bit RST_MODE = 1'b0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         dir,
   input  logic         mode,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] counter,
   output logic         wrap,
   output logic         err
);

   localparam logic [N-1:0] RST_SEED = N'(seed_of(N, RST_MODE));

   logic         mode_q;
   logic         legal;
   logic [N-1:0] seed_cur;
   logic [N-1:0] seed_new;
   logic [N-1:0] adv;
   logic [N-1:0] counter_nxt;
   logic         mode_nxt;
   logic         wrap_nxt;
   logic         err_nxt;

   shift_code_check #(.N(N)) u_check (
      .state (counter),
      .mode  (mode_q),
      .legal (legal)
   );

   // Next-state mux: load, mode switch, correction, advance, hold.
   always_comb begin
      seed_cur    = N'(seed_of(N, mode_q));
      seed_new    = N'(seed_of(N, mode));
      // Johnson differs from ring only by inverting the bit that wraps around.
      if (dir == DIR_RIGHT) begin
         adv = {counter[0] ^ mode_q, counter[N-1:1]};
      end else begin
         adv = {counter[N-2:0], counter[N-1] ^ mode_q};
      end
      counter_nxt = counter;
      mode_nxt    = mode_q;
      wrap_nxt    = 1'b0;
      err_nxt     = 1'b0;
      if (load) begin
         counter_nxt = load_val;
         mode_nxt    = mode;
      end else if (mode != mode_q) begin
         counter_nxt = seed_new;
         mode_nxt    = mode;
      end else if (!legal) begin
         counter_nxt = seed_cur;
         err_nxt     = 1'b1;
      end else if (en) begin
         counter_nxt = adv;
         wrap_nxt    = (adv == seed_cur);
      end
   end

   // State and pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter <= RST_SEED;
         mode_q  <= RST_MODE;
         wrap    <= 1'b0;
         err     <= 1'b0;
      end else begin
         counter <= counter_nxt;
         mode_q  <= mode_nxt;
         wrap    <= wrap_nxt;
         err     <= err_nxt;
      end
   end

endmodule

// File: doc/shift_counter.md
# shift_counter

Parametrised shift-register counter that generalises the fixed-width ring counter. It supports ring (one-hot) and Johnson (twisted-ring) codes, either rotation direction, enable, parallel load, and self-correction of illegal states. It sits in the same counter/sequencer library as the existing ring counter, for use as a one-hot phase generator, Johnson divider or state-decoder driver.

## Interface
- N, default 4: counter width in bits; legal range N >= 2.
- RST_MODE, default 0: mode held at reset; 0 = ring, 1 = Johnson.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  advances the counter one step when high.
- dir  input  1  0 = rotate right (bit 0 moves to MSB), 1 = rotate left (MSB moves to bit 0).
- mode  input  1  0 = ring, 1 = Johnson.
- load  input  1  parallel-load strobe.
- load_val  input  N  value written on load.
- counter  output  N  registered counter state.
- wrap  output  1  registered one-cycle pulse when an advance lands on the seed.
- err  output  1  registered one-cycle pulse when an illegal state was corrected.

## Operation
- Seeds:
  - Ring seed = 1 (only bit 0 set).
  - Johnson seed = all zeros.
- Ring advance:
  - dir=0: next = {c[0], c[N-1:1]}.
  - dir=1: next = {c[N-2:0], c[N-1]}.
  - Period is N.
- Johnson advance:
  - dir=0: next = {~c[0], c[N-1:1]}.
  - dir=1: next = {c[N-2:0], ~c[N-1]}.
  - Period is 2N.
- Legality:
  - Ring: the state is legal iff exactly one bit is set.
  - Johnson: the state is legal iff at most one adjacent pair (c[i], c[i+1]), for i = 0..N-2, differs.
- An internal register mode_q holds the active mode and resets to RST_MODE.
- Per-edge priority, highest first:
  1. load: counter <= load_val verbatim, even if illegal. mode_q <= mode.
  2. mode != mode_q: counter <= seed of the new mode, mode_q <= mode. No err, no wrap.
  3. Current counter illegal for mode_q: counter <= seed, err <= 1. This applies regardless of en.
  4. en: counter <= advance(counter, dir, mode_q). wrap <= 1 iff the result equals the seed.
  5. Otherwise hold.
- wrap and err are 0 on every edge where their condition does not hold.
- dir may change on any cycle. It takes effect on the next advance with no correction, because both directions preserve legality.
- An illegal load_val is accepted, then corrected on the following edge with err.

## Timing
- Reset values, applied asynchronously on reset_n low:
  - counter = seed of RST_MODE.
  - mode_q = RST_MODE.
  - wrap = 0.
  - err = 0.
- Releasing reset takes effect on the first rising edge after reset_n goes high.
- All outputs are registered; there is no combinational input-to-output path.
- Latencies:
  - Advance, load and mode switch: 1 cycle.
  - Illegal-state correction: 1 cycle after the illegal value appears on counter.
- wrap and err are each high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Reset asserted mid-sequence forces the seed immediately, with no clock required, and clears any pending pulse.

## Structure
- Package shift_counter_pkg holds:
  - Mode constants MODE_RING = 1'b0 and MODE_JOHNSON = 1'b1.
  - Direction constants DIR_RIGHT = 1'b0 and DIR_LEFT = 1'b1.
  - A seed function of N and mode.
- One sub-module, shift_code_check (parameter N): combinational; inputs state and mode, output legal.
- The next-state mux and registers live in the top module.

## Test plan
- Reset, ring, dir=0, en=1, N=4: release reset_n → counter sequence 0001, 1000, 0100, 0010, 0001. wrap is high only in the cycle counter shows 0001 after the advance.
- Johnson, mode=1, dir=1, N=4: sequence 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. wrap once per 8 advances.
- Mode switch in ring at 0100: drive mode=1 → next counter 0000, err=0, wrap=0. Then advances follow the Johnson code.
- Illegal load, ring mode: load=1, load_val=0110 → counter 0110 for one cycle, then 0001 with err=1 for one cycle. This also holds with en=0.
- Priority: load=1, en=1 and a mode change in the same cycle → counter = load_val, mode_q = new mode, no advance.
- Async reset mid-run in Johnson at 1110 with RST_MODE=0: pull reset_n low between edges → counter 0001 immediately, wrap=err=0. On release, the next advance follows ring mode if mode=0.
